// File: rtl/reg_write_if.sv
// Write-request channel into the register file: valid/addr/data toward the
// storage owner, ready back toward the issuing pipeline.
interface reg_write_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              ctrl_writeEnable;
    logic [ADDR_W-1:0] ctrl_writeReg;
    logic [DATA_W-1:0] data_writeReg;
    logic              write_ready;

    modport master (
        output ctrl_writeEnable,
        output ctrl_writeReg,
        output data_writeReg,
        input  write_ready
    );

    modport slave (
        input  ctrl_writeEnable,
        input  ctrl_writeReg,
        input  data_writeReg,
        output write_ready
    );
endinterface

// File: rtl/reg_write.sv
// Register-file write port: owns the storage, queues incoming writes in a small
// in-order buffer, commits one per cycle unless held, and flags pending RAW hazards.
module reg_write #(
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       ctrl_reset,
    reg_write_if.slave                 wr,
    input  logic                       ctrl_writeHold,
    input  logic [ADDR_W-1:0]          ctrl_readReg,
    output logic                       read_hazard,
    output logic                       write_pending,
    output logic [15:0]                commit_count,
    output logic [NUM_REGS*DATA_W-1:0] q
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [ADDR_W-1:0]     buf_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]     buf_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] buf_valid;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic                  accept;
    logic                  commit;
    logic [ADDR_W-1:0]     head_addr;
    logic [DATA_W-1:0]     head_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // One valid bit per slot: full/empty fall out directly, and the hazard
    // scan only needs to look at occupied slots.
    assign wr.write_ready = ctrl_reset && !(&buf_valid);
    assign accept         = wr.ctrl_writeEnable && wr.write_ready;
    assign commit         = (|buf_valid) && !ctrl_writeHold;
    assign write_pending  = |buf_valid;
    assign head_addr      = buf_addr[rd_ptr];
    assign head_data      = buf_data[rd_ptr];

    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            buf_valid    <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            commit_count <= '0;
        end else begin
            if (commit) begin
                buf_valid[rd_ptr] <= 1'b0;
                rd_ptr            <= ptr_inc(rd_ptr);
                commit_count      <= commit_count + 16'd1;
            end
            if (accept) begin
                buf_valid[wr_ptr] <= 1'b1;
                wr_ptr            <= ptr_inc(wr_ptr);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            buf_addr[wr_ptr] <= wr.ctrl_writeReg;
            buf_data[wr_ptr] <= wr.data_writeReg;
        end
    end

    always_comb begin
        read_hazard = 1'b0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            if (buf_valid[k] && (buf_addr[k] == ctrl_readReg) && (buf_addr[k] != '0))
                read_hazard = 1'b1;
        end
    end

    // Register 0 has no storage at all; its slice of q is tied off.
    assign q[DATA_W-1:0] = '0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        logic [DATA_W-1:0] r;

        always_ff @(posedge clock) begin
            if (!ctrl_reset)
                r <= '0;
            else if (commit && (head_addr == ADDR_W'(i)))
                r <= head_data;
        end

        assign q[DATA_W*i +: DATA_W] = r;
    end
endmodule

// File: tb/tb_reg_write.sv
// Bench for reg_write: queue-based reference model drives expectations; a
// scoreboard of accepted writes is consumed by a monitor on every commit.
module tb_reg_write;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DEPTH    = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                       ctrl_reset     = 1'b0;
    logic                       ctrl_writeHold = 1'b0;
    logic [ADDR_W-1:0]          ctrl_readReg   = '0;
    logic                       read_hazard;
    logic                       write_pending;
    logic [15:0]                commit_count;
    logic [NUM_REGS*DATA_W-1:0] q;

    reg_write_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wif ();

    reg_write #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock         (clock),
        .ctrl_reset    (ctrl_reset),
        .wr            (wif.slave),
        .ctrl_writeHold(ctrl_writeHold),
        .ctrl_readReg  (ctrl_readReg),
        .read_hazard   (read_hazard),
        .write_pending (write_pending),
        .commit_count  (commit_count),
        .q             (q)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    int          total = 0;
    int          bad   = 0;
    wr_t         mq[$];
    wr_t         sb[$];
    logic [31:0] mregs [NUM_REGS];
    logic [15:0] exp_cc  = '0;
    logic [15:0] last_cc = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_q(input string name);
        int idx;
        idx = -1;
        for (int i = 0; i < NUM_REGS; i++)
            if (idx < 0 && q[DATA_W*i +: DATA_W] !== mregs[i]) idx = i;
        total++;
        if (idx >= 0) begin
            bad++;
            $display("FAIL %s: r%0d got %0h expected %0h", name, idx,
                     q[DATA_W*idx +: DATA_W], mregs[idx]);
        end
    endtask

    // One clock of stimulus; checks combinational outputs against the queue model.
    task automatic step(input logic en, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic hold, input logic [ADDR_W-1:0] rd, input logic rst);
        bit  exp_ready;
        bit  exp_haz;
        wr_t e;
        @(negedge clock);
        wif.ctrl_writeEnable = en;
        wif.ctrl_writeReg    = a;
        wif.data_writeReg    = d;
        ctrl_writeHold       = hold;
        ctrl_readReg         = rd;
        ctrl_reset           = rst;
        #1;
        exp_ready = rst && (mq.size() < DEPTH);
        exp_haz   = 1'b0;
        foreach (mq[k]) if (mq[k].addr == rd && rd != 0) exp_haz = 1'b1;
        check("write_ready", {31'b0, wif.write_ready}, {31'b0, exp_ready});
        check("read_hazard", {31'b0, read_hazard}, {31'b0, exp_haz});
        check("write_pending", {31'b0, write_pending}, {31'b0, mq.size() != 0});
        if (!rst) begin
            mq.delete();
            sb.delete();
        end else begin
            if (mq.size() != 0 && !hold) void'(mq.pop_front());
            if (en && exp_ready) begin
                e.addr = a;
                e.data = d;
                mq.push_back(e);
                sb.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n, input logic hold, input logic [ADDR_W-1:0] rd);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, hold, rd, 1'b1);
    endtask

    // Monitor: every change of commit_count is one commit; pop and compare.
    initial begin
        logic rst_at;
        wr_t  e;
        forever begin
            @(posedge clock);
            rst_at = ctrl_reset;
            #3;
            if (!rst_at) begin
                for (int i = 0; i < NUM_REGS; i++) mregs[i] = '0;
                exp_cc = '0;
                check("reset_commit_count", {16'b0, commit_count}, 32'h0);
                check_q("reset_q");
                last_cc = commit_count;
            end else if (commit_count !== last_cc) begin
                last_cc = commit_count;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_commit: got count %0h with nothing buffered", commit_count);
                end else begin
                    e = sb.pop_front();
                    if (e.addr != 0) mregs[e.addr] = e.data;
                    exp_cc = exp_cc + 16'd1;
                    check("commit_count", {16'b0, commit_count}, {16'b0, exp_cc});
                    check_q("commit_q");
                end
            end
        end
    end

    initial begin
        wif.ctrl_writeEnable = 1'b0;
        wif.ctrl_writeReg    = '0;
        wif.data_writeReg    = '0;
        for (int i = 0; i < NUM_REGS; i++) mregs[i] = '0;

        // reset held two cycles, then released
        step(1'b0, '0, '0, 1'b0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b0, '0, 1'b0);
        idle(1, 1'b0, '0);
        check("t1_count", {16'b0, commit_count}, 32'h0);

        // single write, immediate commit
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 1'b1);
        idle(2, 1'b0, 5'd5);
        check("t2_r5", q[DATA_W*5 +: DATA_W], 32'hDEADBEEF);
        check("t2_count", {16'b0, commit_count}, 32'h1);

        // fill under hold, third request stalls, then drain
        step(1'b1, 5'd1, 32'd1, 1'b1, 5'd2, 1'b1);
        step(1'b1, 5'd2, 32'd2, 1'b1, 5'd2, 1'b1);
        step(1'b1, 5'd3, 32'd3, 1'b1, 5'd2, 1'b1);
        check("t3_full_ready", {31'b0, wif.write_ready}, 32'h0);
        check("t3_hazard", {31'b0, read_hazard}, 32'h1);
        step(1'b1, 5'd3, 32'd3, 1'b0, 5'd2, 1'b1);
        step(1'b1, 5'd3, 32'd3, 1'b0, 5'd2, 1'b1);
        idle(3, 1'b0, 5'd3);
        check("t3_r3", q[DATA_W*3 +: DATA_W], 32'd3);

        // register 0 absorbs writes
        step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b1);
        idle(2, 1'b0, 5'd0);
        check("t4_r0", q[DATA_W-1:0], 32'h0);
        check("t4_count", {16'b0, commit_count}, 32'd5);

        // same-register writes, later wins
        step(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 1'b1);
        step(1'b1, 5'd7, 32'h2, 1'b1, 5'd7, 1'b1);
        idle(3, 1'b0, 5'd7);
        check("t5_r7", q[DATA_W*7 +: DATA_W], 32'h2);

        // reset discards buffered entries
        step(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 1'b1);
        step(1'b1, 5'd10, 32'hAA, 1'b1, 5'd10, 1'b1);
        step(1'b0, '0, '0, 1'b1, 5'd9, 1'b0);
        idle(3, 1'b0, 5'd9);
        check("t6_count", {16'b0, commit_count}, 32'h0);
        check("t6_r9", q[DATA_W*9 +: DATA_W], 32'h0);

        // randomized traffic with occasional reset
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), ADDR_W'($urandom), $urandom,
                 1'($urandom_range(0, 1)), ADDR_W'($urandom),
                 1'($urandom_range(0, 59) != 0));
        idle(4, 1'b0, '0);
        check("drain_scoreboard", sb.size(), 32'h0);

        // commit_count wrap: exactly 65536 commits from zero
        step(1'b0, '0, '0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 65536; i++)
            step(1'b1, ADDR_W'($urandom_range(1, NUM_REGS - 1)), $urandom, 1'b0, '0, 1'b1);
        idle(4, 1'b0, '0);
        check("t7_wrap", {16'b0, commit_count}, 32'h0);
        check("t7_scoreboard", sb.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
